enc_pwm_mixer: RTL

- N-channel successor to the 3-channel RGB mixer: each channel takes a mechanical quadrature encoder, synchronises and debounces it, and decodes it into a W-bit level.
- The level drives a glitch-free PWM output; duty changes take effect only at period boundaries.
- Generalised over channel count, level width, debounce length, decode mode (x1/x4), step size, saturate-vs-wrap and PWM prescale.
- Sits at top level between board encoder pins and LED driver pins.

---
 rtl/enc_pwm_mixer.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/enc_pwm_mixer.sv
// enc_pwm_mixer: N-channel quadrature encoder to PWM level mixer.
// Ports: clk, reset_N (sync, active-low), enc_a/enc_b (async encoder
// pins per channel), pwm_out (per channel), level (NCH*W packed levels),
// period_start (one-cycle pulse after the PWM counter wraps to 0).

module enc_pwm_mixer #(
   parameter int NCH        = 3,
   parameter int W          = 8,
   parameter int DB_CYCLES  = 255,
   parameter int DECODE_X4  = 0,
   parameter int STEP       = 1,
   parameter int SATURATE   = 1,
   parameter int PRESCALE   = 64,
   parameter int INIT_LEVEL = 0
) (
   input  logic             clk,
   input  logic             reset_N,
   input  logic [NCH-1:0]   enc_a,
   input  logic [NCH-1:0]   enc_b,
   output logic [NCH-1:0]   pwm_out,
   output logic [NCH*W-1:0] level,
   output logic             period_start
);

   localparam int DBW = (DB_CYCLES < 1) ? 1 : $clog2(DB_CYCLES + 1);
   localparam int PSW = (PRESCALE < 2) ? 1 : $clog2(PRESCALE);
   localparam int NIN = 2 * NCH;

   localparam logic [DBW-1:0] DB_MAX   = DBW'(DB_CYCLES);
   localparam logic [PSW-1:0] PS_MAX   = PSW'(PRESCALE - 1);
   localparam logic [W-1:0]   LVL_MAX  = '1;
   localparam logic [W-1:0]   LVL_INIT = W'(INIT_LEVEL);
   localparam logic [W:0]     STEP_X   = (W + 1)'(STEP);

   // Input bit k: a of channel k for k < NCH, b of channel k-NCH above.
   logic [NIN-1:0] raw;
   logic [NIN-1:0] s1_q;
   logic [NIN-1:0] s2_q;

   assign raw = {enc_b, enc_a};

   always_ff @(posedge clk) begin
      if (!reset_N) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= raw;
         s2_q <= s1_q;
      end
   end

   // Debounce: a change is accepted once the counter has reached
   // DB_CYCLES and the input still differs, so DB_CYCLES=0 gives a
   // plain one-cycle follower.
   logic [NIN-1:0] deb_q;
   logic [NIN-1:0] deb_d;
   logic [DBW-1:0] dbc_q [NIN];
   logic [DBW-1:0] dbc_d [NIN];

   always_comb begin
      deb_d = deb_q;
      for (int k = 0; k < NIN; k++) begin
         dbc_d[k] = '0;
         if (s2_q[k] != deb_q[k]) begin
            if (dbc_q[k] == DB_MAX) begin
               deb_d[k] = s2_q[k];
            end else begin
               dbc_d[k] = dbc_q[k] + DBW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_N) begin
         deb_q <= '0;
         for (int k = 0; k < NIN; k++) begin
            dbc_q[k] <= '0;
         end
      end else begin
         deb_q <= deb_d;
         for (int k = 0; k < NIN; k++) begin
            dbc_q[k] <= dbc_d[k];
         end
      end
   end

   // Decode: compare previous and current debounced {a,b}.
   logic [NIN-1:0] prev_q;
   logic [NCH-1:0] up;
   logic [NCH-1:0] dn;
   logic [3:0]     tr;

   always_ff @(posedge clk) begin
      if (!reset_N) begin
         prev_q <= '0;
      end else begin
         prev_q <= deb_q;
      end
   end

   always_comb begin
      up = '0;
      dn = '0;
      tr = '0;
      for (int i = 0; i < NCH; i++) begin
         tr = {prev_q[i], prev_q[NCH+i], deb_q[i], deb_q[NCH+i]};
         if (DECODE_X4 != 0) begin
            // Gray sequence 00,10,11,01; double-bit jumps fall to default.
            case (tr)
               4'b0010, 4'b1011, 4'b1101, 4'b0100: up[i] = 1'b1;
               4'b1000, 4'b1110, 4'b0111, 4'b0001: dn[i] = 1'b1;
               default: ;
            endcase
         end else begin
            up[i] = !tr[3] && tr[1] && !tr[0];
            dn[i] = !tr[3] && tr[1] && tr[0];
         end
      end
   end

   // Level update with one spare bit to catch carry and borrow.
   logic [W-1:0] lvl_q [NCH];
   logic [W-1:0] lvl_d [NCH];
   logic [W:0]   sum;
   logic [W:0]   dif;

   always_comb begin
      sum = '0;
      dif = '0;
      for (int i = 0; i < NCH; i++) begin
         lvl_d[i] = lvl_q[i];
         sum = {1'b0, lvl_q[i]} + STEP_X;
         dif = {1'b0, lvl_q[i]} - STEP_X;
         if (up[i]) begin
            lvl_d[i] = (sum[W] && SATURATE != 0) ? LVL_MAX : sum[W-1:0];
         end else if (dn[i]) begin
            lvl_d[i] = (dif[W] && SATURATE != 0) ? '0 : dif[W-1:0];
         end
      end
   end

   // Shared PWM timebase.
   logic [PSW-1:0] ps_q;
   logic [PSW-1:0] ps_d;
   logic [W-1:0]   cnt_q;
   logic [W-1:0]   cnt_d;
   logic           tick;
   logic           wrap;

   always_comb begin
      tick  = (ps_q == PS_MAX);
      wrap  = tick && (cnt_q == LVL_MAX);
      ps_d  = tick ? '0 : ps_q + PSW'(1);
      cnt_d = tick ? cnt_q + W'(1) : cnt_q;
   end

   // Duty shadow is loaded on the wrapping tick, so it takes the level
   // as it stood before any same-cycle update.
   logic [W-1:0]   duty_q [NCH];
   logic [NCH-1:0] pwm_q;
   logic           pstart_q;

   always_ff @(posedge clk) begin
      if (!reset_N) begin
         ps_q     <= '0;
         cnt_q    <= '0;
         pwm_q    <= '0;
         pstart_q <= 1'b0;
         for (int i = 0; i < NCH; i++) begin
            lvl_q[i]  <= LVL_INIT;
            duty_q[i] <= LVL_INIT;
         end
      end else begin
         ps_q     <= ps_d;
         cnt_q    <= cnt_d;
         pstart_q <= wrap;
         for (int i = 0; i < NCH; i++) begin
            lvl_q[i] <= lvl_d[i];
            pwm_q[i] <= (cnt_q < duty_q[i]);
            if (wrap) begin
               duty_q[i] <= lvl_q[i];
            end
         end
      end
   end

   always_comb begin
      level = '0;
      for (int i = 0; i < NCH; i++) begin
         level[i*W +: W] = lvl_q[i];
      end
   end

   assign pwm_out      = pwm_q;
   assign period_start = pstart_q;

endmodule
